// File: rtl/biquad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : biquad_pkg
// Purpose  : Shared types and helpers for the time-multiplexed biquad cascade:
//            coefficient slot order, FSM state encoding and the accumulator
//            saturation helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package biquad_pkg;

  // Coefficients are stored per stage in this order.
  localparam int NUM_COEF = 5;

  // The saturation helper works on a fixed 64-bit view of the accumulator;
  // narrower accumulators are sign-extended before the call.
  localparam int SAT_IN_W = 64;

  typedef enum logic [2:0] {
    C_B0 = 3'd0,
    C_B1 = 3'd1,
    C_B2 = 3'd2,
    C_A1 = 3'd3,
    C_A2 = 3'd4
  } coef_idx_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [SAT_IN_W-1:0] value;
    logic                       flag;
  } sat_res_t;

  // Clamp v into the signed range of a w-bit word; flag reports clipping.
  function automatic sat_res_t saturate(input logic signed [SAT_IN_W-1:0] v,
                                        input int unsigned w);
    sat_res_t                   r;
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      r.value = hi;
      r.flag  = 1'b1;
    end else if (v < lo) begin
      r.value = lo;
      r.flag  = 1'b1;
    end else begin
      r.value = v;
      r.flag  = 1'b0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/biquad_mac.sv
`default_nettype none
// ============================================================================
// Module   : biquad_mac
// Purpose  : Shared multiply / arithmetic-shift / accumulate datapath. Each
//            enabled cycle adds (or subtracts) one floor-shifted product term.
// Ports    : clk_in, rst_in      - clock, synchronous active-high reset
//            en_in               - accumulate this cycle
//            clear_in            - start a new sum with this term
//            sub_in              - subtract the term instead of adding it
//            operand_in, coef_in - signed multiplicands
//            acc_out             - registered accumulator
// Revision : 1.0 - initial release
// ============================================================================
module biquad_mac #(
  parameter int WIDTH      = 24,
  parameter int COEF_WIDTH = 32,
  parameter int SHIFT      = 20,
  parameter int ACC_WIDTH  = 64
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         en_in,
  input  logic                         clear_in,
  input  logic                         sub_in,
  input  logic signed [WIDTH-1:0]      operand_in,
  input  logic signed [COEF_WIDTH-1:0] coef_in,
  output logic signed [ACC_WIDTH-1:0]  acc_out
);

  localparam int PW = WIDTH + COEF_WIDTH;

  logic signed [PW-1:0]        w_prod;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] w_term;
  logic signed [ACC_WIDTH-1:0] w_base;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  assign w_prod = operand_in * coef_in;
  // Sign-extend before shifting so each term is floored on its own.
  assign w_ext  = ACC_WIDTH'(w_prod);
  assign w_term = w_ext >>> SHIFT;

  always_comb begin
    acc_d  = acc_q;
    w_base = clear_in ? '0 : acc_q;
    if (en_in) begin
      acc_d = sub_in ? (w_base - w_term) : (w_base + w_term);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_out = acc_q;

endmodule
`default_nettype wire

// File: rtl/biquad_cascade_tdm.sv
`default_nettype none
// ============================================================================
// Module   : biquad_cascade_tdm
// Purpose  : Runtime-programmable cascade of N_STAGES Direct Form I biquads
//            for N_CH channels, sharing one MAC. Each stage takes 5 MAC
//            cycles plus one write-back cycle.
// Ports    : clk_in, rst_in                 - clock, sync active-high reset
//            sample_in, ch_in, valid_in     - input sample with channel
//            ready_out                      - idle, sample accepted on valid
//            sample_out, ch_out, valid_out  - filtered result (1-cycle pulse)
//            sat_out                        - some stage clipped this sample
//            coef_we_in/addr_in/data_in     - coefficient write (stage*5+k)
//            clr_in                         - clear history, abort sample
// Revision : 1.0 - initial release
// ============================================================================
module biquad_cascade_tdm
  import biquad_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int COEF_WIDTH = 32,
  parameter int SHIFT      = 20,
  parameter int N_CH       = 2,
  parameter int N_STAGES   = 2,
  parameter int ACC_WIDTH  = 64
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic signed [WIDTH-1:0]                sample_in,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_in,
  input  logic                                   valid_in,
  output logic                                   ready_out,
  output logic signed [WIDTH-1:0]                sample_out,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_out,
  output logic                                   valid_out,
  output logic                                   sat_out,
  input  logic                                   coef_we_in,
  input  logic [$clog2(5*N_STAGES)-1:0]          coef_addr_in,
  input  logic signed [COEF_WIDTH-1:0]           coef_data_in,
  input  logic                                   clr_in
);

  localparam int CHW       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int STW       = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int NCOEF_ALL = NUM_COEF * N_STAGES;
  localparam int NHIST     = N_CH * N_STAGES;
  localparam logic signed [COEF_WIDTH-1:0] C_UNITY = COEF_WIDTH'(64'd1 << SHIFT);

  // FSM and sequencing
  state_e                  state_q, state_d;
  coef_idx_e               k_q;
  logic [STW-1:0]          stage_q;
  logic [CHW-1:0]          ch_q;
  logic signed [WIDTH-1:0] x_cur_q;
  logic                    sat_acc_q;

  // Storage
  logic signed [COEF_WIDTH-1:0] coef_q [NCOEF_ALL];
  logic signed [WIDTH-1:0]      x1_q   [NHIST];
  logic signed [WIDTH-1:0]      x2_q   [NHIST];
  logic signed [WIDTH-1:0]      y1_q   [NHIST];
  logic signed [WIDTH-1:0]      y2_q   [NHIST];

  // Registered outputs
  logic signed [WIDTH-1:0] sample_q;
  logic [CHW-1:0]          ch_out_q;
  logic                    valid_q;
  logic                    sat_q;

  // Combinational helpers
  logic                         w_ch_ok;
  logic                         w_accept;
  logic                         w_last;
  logic                         w_mac_en;
  logic                         w_ready;
  logic                         w_addr_ok;
  int                           w_hidx;
  int                           w_cidx;
  logic signed [WIDTH-1:0]      w_operand;
  logic                         w_sub;
  logic signed [ACC_WIDTH-1:0]  w_acc;
  logic signed [SAT_IN_W-1:0]   w_acc64;
  sat_res_t                     w_sat;
  logic signed [WIDTH-1:0]      w_y;
  logic                         w_unused_sat;

  // Out-of-range channels only exist when N_CH is not a power of two.
  generate
    if (N_CH == (1 << CHW)) begin : g_ch_full
      assign w_ch_ok = 1'b1;
    end else begin : g_ch_chk
      assign w_ch_ok = (int'(ch_in) < N_CH);
    end
  endgenerate

  assign w_accept  = valid_in && w_ready && w_ch_ok && !clr_in;
  assign w_last    = (stage_q == STW'(N_STAGES - 1));
  assign w_addr_ok = (int'(coef_addr_in) < NCOEF_ALL);
  assign w_hidx    = int'(ch_q) * N_STAGES + int'(stage_q);
  assign w_cidx    = int'(stage_q) * NUM_COEF + int'(k_q);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = S_MAC;
      S_MAC:   if (k_q == C_A2) state_d = S_WB;
      S_WB:    state_d = w_last ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr_in) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    w_ready  = (state_q == S_IDLE);
    w_mac_en = (state_q == S_MAC);
  end

  // ---------------------------------------------------------- MAC feed
  always_comb begin
    w_operand = x_cur_q;
    w_sub     = 1'b0;
    case (k_q)
      C_B0:    w_operand = x_cur_q;
      C_B1:    w_operand = x1_q[w_hidx];
      C_B2:    w_operand = x2_q[w_hidx];
      C_A1: begin
        w_operand = y1_q[w_hidx];
        w_sub     = 1'b1;
      end
      C_A2: begin
        w_operand = y2_q[w_hidx];
        w_sub     = 1'b1;
      end
      default: w_operand = x_cur_q;
    endcase
  end

  biquad_mac #(
    .WIDTH      (WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .SHIFT      (SHIFT),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en_in      (w_mac_en),
    .clear_in   (k_q == C_B0),
    .sub_in     (w_sub),
    .operand_in (w_operand),
    .coef_in    (coef_q[w_cidx]),
    .acc_out    (w_acc)
  );

  assign w_acc64      = SAT_IN_W'(w_acc);
  assign w_sat        = saturate(w_acc64, WIDTH);
  assign w_y          = w_sat.value[WIDTH-1:0];
  assign w_unused_sat = ^w_sat.value[SAT_IN_W-1:WIDTH];

  // ------------------------------------------------------- sequencing
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      k_q       <= C_B0;
      stage_q   <= '0;
      ch_q      <= '0;
      x_cur_q   <= '0;
      sat_acc_q <= 1'b0;
    end else if (clr_in) begin
      k_q       <= C_B0;
      stage_q   <= '0;
      sat_acc_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            x_cur_q   <= sample_in;
            ch_q      <= ch_in;
            k_q       <= C_B0;
            stage_q   <= '0;
            sat_acc_q <= 1'b0;
          end
        end
        S_MAC: begin
          if (k_q != C_A2) begin
            k_q <= coef_idx_e'(k_q + 3'd1);
          end
        end
        S_WB: begin
          k_q       <= C_B0;
          x_cur_q   <= w_y;
          sat_acc_q <= sat_acc_q | w_sat.flag;
          if (!w_last) begin
            stage_q <= stage_q + STW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------ history
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      for (int i = 0; i < NHIST; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else if (state_q == S_WB) begin
      x2_q[w_hidx] <= x1_q[w_hidx];
      x1_q[w_hidx] <= x_cur_q;
      y2_q[w_hidx] <= y1_q[w_hidx];
      y1_q[w_hidx] <= w_y;
    end
  end

  // ------------------------------------------------------- coefficients
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NCOEF_ALL; i++) begin
        coef_q[i] <= ((i % NUM_COEF) == 0) ? C_UNITY : '0;
      end
    end else if (coef_we_in && w_ready && w_addr_ok) begin
      coef_q[coef_addr_in] <= coef_data_in;
    end
  end

  // ------------------------------------------------------------ outputs
  // Results are captured at the last write-back so they appear in DONE.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sample_q <= '0;
      ch_out_q <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!clr_in && (state_q == S_WB) && w_last) begin
        valid_q  <= 1'b1;
        sample_q <= w_y;
        ch_out_q <= ch_q;
        sat_q    <= sat_acc_q | w_sat.flag;
      end
    end
  end

  assign ready_out  = w_ready;
  assign sample_out = sample_q;
  assign ch_out     = ch_out_q;
  assign valid_out  = valid_q;
  assign sat_out    = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_biquad_cascade_tdm.sv
`default_nettype none
// ============================================================================
// Module   : tb_biquad_cascade_tdm
// Purpose  : Self-checking bench for biquad_cascade_tdm (N_CH=3) against a
//            plain-arithmetic per-channel cascade model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_biquad_cascade_tdm;

  localparam int W   = 24;
  localparam int CW  = 32;
  localparam int SH  = 20;
  localparam int NCH = 3;
  localparam int NST = 2;
  localparam int AW  = 64;
  localparam int ONE = 1 << SH;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic signed [W-1:0]  sample_in;
  logic [1:0]           ch_in;
  logic                 valid_in;
  logic                 ready_out;
  logic signed [W-1:0]  sample_out;
  logic [1:0]           ch_out;
  logic                 valid_out;
  logic                 sat_out;
  logic                 coef_we_in;
  logic [3:0]           coef_addr_in;
  logic signed [CW-1:0] coef_data_in;
  logic                 clr_in;

  biquad_cascade_tdm #(
    .WIDTH(W), .COEF_WIDTH(CW), .SHIFT(SH), .N_CH(NCH), .N_STAGES(NST), .ACC_WIDTH(AW)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .sample_in    (sample_in),
    .ch_in        (ch_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .sample_out   (sample_out),
    .ch_out       (ch_out),
    .valid_out    (valid_out),
    .sat_out      (sat_out),
    .coef_we_in   (coef_we_in),
    .coef_addr_in (coef_addr_in),
    .coef_data_in (coef_data_in),
    .clr_in       (clr_in)
  );

  always #5 clk_in = ~clk_in;

  int     n_total = 0;
  int     n_bad   = 0;
  longint last_y;
  longint last_sat;

  // Reference model state
  int m_coef [NST*5];
  int mx1 [NCH][NST];
  int mx2 [NCH][NST];
  int my1 [NCH][NST];
  int my2 [NCH][NST];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void m_reset_hist();
    for (int c = 0; c < NCH; c++) begin
      for (int s = 0; s < NST; s++) begin
        mx1[c][s] = 0; mx2[c][s] = 0; my1[c][s] = 0; my2[c][s] = 0;
      end
    end
  endfunction

  function automatic void m_reset_coef();
    for (int i = 0; i < NST*5; i++) m_coef[i] = ((i % 5) == 0) ? ONE : 0;
  endfunction

  function automatic longint term(input int c, input int v);
    return (longint'(c) * longint'(v)) >>> SH;
  endfunction

  function automatic void m_step(input int ch, input int x, output int y, output int sat);
    int     xs;
    int     ys;
    longint acc;
    xs  = x;
    sat = 0;
    for (int s = 0; s < NST; s++) begin
      acc = term(m_coef[s*5], xs) + term(m_coef[s*5+1], mx1[ch][s])
          + term(m_coef[s*5+2], mx2[ch][s]) - term(m_coef[s*5+3], my1[ch][s])
          - term(m_coef[s*5+4], my2[ch][s]);
      if (acc > 64'sd8388607) begin
        ys = 8388607; sat = 1;
      end else if (acc < -64'sd8388608) begin
        ys = -8388608; sat = 1;
      end else begin
        ys = int'(acc);
      end
      mx2[ch][s] = mx1[ch][s]; mx1[ch][s] = xs;
      my2[ch][s] = my1[ch][s]; my1[ch][s] = ys;
      xs = ys;
    end
    y = xs;
  endfunction

  task automatic wcoef(input int addr, input int data);
    coef_we_in = 1'b1; coef_addr_in = 4'(addr); coef_data_in = data;
    tick();
    coef_we_in = 1'b0;
    if (addr < NST*5) m_coef[addr] = data;
  endtask

  task automatic clear_hist();
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    m_reset_hist();
  endtask

  task automatic no_valid_for(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      if (valid_out) seen = 1;
      tick();
    end
    chk(tag, seen, 0);
  endtask

  // One sample through the pipe. Optional write in the handshake cycle
  // (visible to this sample) and optional write while busy (dropped).
  task automatic send(input int ch, input int x, input bit wr = 0, input int addr = 0,
                      input int data = 0, input bit busy_wr = 0);
    int ey, es, lat;
    chk("ready_idle", ready_out, 1);
    valid_in = 1'b1; sample_in = W'(x); ch_in = 2'(ch);
    if (wr) begin
      coef_we_in = 1'b1; coef_addr_in = 4'(addr); coef_data_in = data;
      if (addr < NST*5) m_coef[addr] = data;
    end
    tick();
    valid_in = 1'b0; coef_we_in = 1'b0;
    lat = 1;
    if (ch >= NCH) begin
      chk("badch_ready", ready_out, 1);
      no_valid_for("badch_novalid", 16);
      return;
    end
    m_step(ch, x, ey, es);
    if (busy_wr) begin
      chk("busy_ready", ready_out, 0);
      coef_we_in = 1'b1; coef_addr_in = 4'd0; coef_data_in = 0;
      tick();
      coef_we_in = 1'b0;
      lat++;
    end
    while (!valid_out && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", lat, 13);
    chk("sample_out", sample_out, ey);
    chk("ch_out", ch_out, ch);
    chk("sat_out", sat_out, es);
    last_y   = sample_out;
    last_sat = sat_out;
    tick();
    chk("ready_after", ready_out, 1);
    chk("pulse_width", valid_out, 0);
    chk("hold", sample_out, ey);
  endtask

  initial begin
    int imp_exp [4];
    rst_in = 1'b1; valid_in = 1'b0; sample_in = '0; ch_in = '0;
    coef_we_in = 1'b0; coef_addr_in = '0; coef_data_in = '0; clr_in = 1'b0;
    m_reset_coef();
    m_reset_hist();
    repeat (3) tick();
    rst_in = 1'b0;
    chk("rst_ready", ready_out, 1);
    chk("rst_valid", valid_out, 0);
    chk("rst_sample", sample_out, 0);
    chk("rst_ch", ch_out, 0);
    chk("rst_sat", sat_out, 0);

    // Passthrough after reset
    send(0, 1000);
    chk("t1_pass", last_y, 1000);

    // FIR impulse on stage 0
    wcoef(0, 524288); wcoef(1, 524288); wcoef(2, 524288);
    clear_hist();
    imp_exp = '{2048, 2048, 2048, 0};
    for (int i = 0; i < 4; i++) begin
      send(0, (i == 0) ? 4096 : 0);
      chk("t2_fir", last_y, imp_exp[i]);
    end

    // Feedback on ch0 with ch1 interleaved
    wcoef(0, ONE); wcoef(1, 0); wcoef(2, 0); wcoef(3, -524288);
    clear_hist();
    for (int i = 0; i < 4; i++) begin
      send(0, (i == 0) ? 4096 : 0);
      chk("t3_iir", last_y, 4096 >> i);
      send(1, 0);
      chk("t3_iso", last_y, 0);
    end

    // Saturation
    wcoef(3, 0); wcoef(0, 4 << 20);
    clear_hist();
    send(0, 4000000);
    chk("t4_pos", last_y, 8388607);
    chk("t4_psat", last_sat, 1);
    send(0, -4000000);
    chk("t4_neg", last_y, -8388608);
    chk("t4_nsat", last_sat, 1);

    // Busy write is dropped; out-of-range channel is discarded
    wcoef(0, ONE);
    send(0, 1234, 0, 0, 0, 1);
    send(0, 1234);
    chk("t5_dropped", last_y, 1234);
    send(3, 777);
    send(2, 555);
    chk("t5_after_bad", last_y, 555);

    // Write in the handshake cycle applies to that sample
    send(0, 1000, 1, 0, 2 << 20);
    chk("same_cycle_wr", last_y, 2000);
    wcoef(0, ONE);
    wcoef(12, 99);   // beyond the coefficient map, ignored

    // Abort by clr in MAC
    wcoef(3, -524288);
    clear_hist();
    send(0, 4096);
    valid_in = 1'b1; sample_in = 24'sd5000; ch_in = 2'd0;
    tick();
    valid_in = 1'b0;
    tick();
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    m_reset_hist();
    chk("clr_ready", ready_out, 1);
    no_valid_for("clr_novalid", 20);
    send(0, 4096);
    chk("clr_fresh", last_y, 4096);

    // Abort by reset mid-sample
    valid_in = 1'b1; sample_in = 24'sd3000; ch_in = 2'd1;
    tick();
    valid_in = 1'b0;
    repeat (4) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    m_reset_hist();
    m_reset_coef();
    chk("rst2_ready", ready_out, 1);
    chk("rst2_sample", sample_out, 0);
    no_valid_for("rst2_novalid", 20);
    send(1, 4096);
    chk("rst2_fresh", last_y, 4096);

    // Randomized coefficients, channels and samples
    for (int n = 0; n < 40; n++) begin
      if ((n % 5) == 0) begin
        for (int j = 0; j < 3; j++) begin
          wcoef(int'($urandom_range(0, 15)), int'($urandom_range(0, 4 << 20)) - (2 << 20));
        end
      end
      if ((n % 7) == 3) begin
        send(int'($urandom_range(0, 3)), int'($urandom_range(0, (1 << 24) - 1)) - (1 << 23),
             1, int'($urandom_range(0, 9)), int'($urandom_range(0, 2 << 20)) - (1 << 20));
      end else begin
        send(int'($urandom_range(0, 3)), int'($urandom_range(0, (1 << 24) - 1)) - (1 << 23));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/biquad_cascade_tdm.md
Name: biquad_cascade_tdm

Overview:
- Time-multiplexed, runtime-programmable cascade of N_STAGES Direct Form I biquad sections serving N_CH independent channels.
- Uses one shared multiply/shift/accumulate datapath.
- Sits after the audio sample source and before the downstream effect blocks.
- Replaces the fixed-coefficient, single-channel, one-sample-per-clock filter with:
  - a valid/ready handshake,
  - saturation,
  - per-channel history,
  - coefficient writes at run time.

Parameters:
- WIDTH, 24, sample width (signed).
- COEF_WIDTH, 32, coefficient width (signed, fixed-point with SHIFT fractional bits).
- SHIFT, 20, fractional bits of the coefficients.
- N_CH, 2, channel count (>=1).
- N_STAGES, 2, cascaded sections per channel (>=1).
- ACC_WIDTH, 64, accumulator width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- sample_in  input  WIDTH  signed input sample.
- ch_in  input  max(1,$clog2(N_CH))  channel of sample_in.
- valid_in  input  1  sample_in/ch_in valid.
- ready_out  output  1  block idle; a sample is accepted on valid_in&&ready_out.
- sample_out  output  WIDTH  filtered, saturated sample.
- ch_out  output  max(1,$clog2(N_CH))  channel of sample_out.
- valid_out  output  1  one-cycle pulse; sample_out/ch_out valid.
- sat_out  output  1  qualified by valid_out; some stage saturated for this sample.
- coef_we_in  input  1  coefficient write strobe.
- coef_addr_in  input  $clog2(5*N_STAGES)  address = stage*5+k, with k order B0,B1,B2,A1,A2.
- coef_data_in  input  COEF_WIDTH  coefficient value.
- clr_in  input  1  zero all filter history and abort any in-flight sample.

Behaviour:
- Reset:
  - ready_out=1; valid_out=0; sample_out=0; ch_out=0; sat_out=0.
  - All history (x1,x2,y1,y2 per channel per stage) is 0.
  - Coefficients are passthrough: B0=1<<SHIFT, all others 0.
  - Reset mid-operation aborts the sample; no valid_out is produced.
- Each stage computes y = (b0*x>>>S)+(b1*x1>>>S)+(b2*x2>>>S)-(a1*y1>>>S)-(a2*y2>>>S).
  - Each product is sign-extended to ACC_WIDTH and shifted arithmetically (floor) individually before accumulation.
  - The sum is saturated to the WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - The saturated y feeds the next stage as its x and is stored as that stage's y1.
- FSM states:
  - IDLE: ready_out=1. On handshake, latch sample and channel; go to MAC with stage=0, k=0.
  - MAC: 5 cycles, one product per cycle, k=0..4; then go to WB.
  - WB: 1 cycle. Saturate; shift the channel/stage history (x2<=x1, x1<=x, y2<=y1, y1<=y). Then go to MAC with stage+1, or go to DONE after the last stage.
  - DONE: drive outputs registered; valid_out=1 for exactly one cycle; return to IDLE.
- Latency and throughput:
  - Handshake at cycle 0 gives valid_out at cycle 6*N_STAGES+1 (13 with defaults).
  - ready_out returns to 1 in the cycle after valid_out.
  - Throughput is one sample per 6*N_STAGES+2 cycles.
- Outputs hold their value between valid_out pulses.
- sat_out is the OR of the stage saturation flags for that sample.
- Coefficient writes:
  - Honoured only while ready_out=1; dropped otherwise.
  - A write in the same IDLE cycle as a sample handshake is visible to that sample.
  - Writes to addresses >=5*N_STAGES are ignored.
- Channel range: ch_in >= N_CH is still handshaken but the sample is discarded. No history is updated, no valid_out is produced, and ready_out returns next cycle.
- clr_in is honoured in every state and has priority over the handshake.
  - It zeros all history and returns to IDLE.
  - It suppresses any pending valid_out.
  - It leaves coefficients unchanged.
- Channels are fully isolated; only the addressed channel's history changes.

Decomposition:
- biquad_pkg holds:
  - the coefficient index enum (B0,B1,B2,A1,A2) and NUM_COEF=5;
  - the FSM state enum (IDLE, MAC, WB, DONE);
  - a saturate function (ACC_WIDTH to WIDTH, with flag).
- One sub-module, biquad_mac, is natural:
  - inputs: operand, coefficient, clear, subtract;
  - registered ACC_WIDTH accumulator;
  - the multiply and per-term arithmetic shift.
- Top level holds the FSM, coefficient registers and history registers.

Test Plan:
1. Post-reset passthrough: ch0 sample 1000 -> valid_out 13 cycles after handshake, sample_out=1000, ch_out=0, sat_out=0.
2. FIR impulse: stage0 B0=B1=B2=524288, stage1 passthrough; ch0 inputs 4096,0,0,0 -> outputs 2048,2048,2048,0.
3. Feedback and isolation: stage0 A1=-524288; ch0 impulse 4096 interleaved with ch1 zeros -> ch0 outputs 4096,2048,1024,512, ch1 outputs all 0.
4. Saturation: stage0 B0=4<<20; input 4000000 -> 8388607 with sat_out=1; input -4000000 -> -8388608 with sat_out=1.
5. Busy rules: coefficient write while ready_out=0 -> dropped, next sample unchanged. ch_in=3 with N_CH=3 -> no valid_out, ready_out back next cycle.
6. Abort: clr_in in MAC, and separately rst_in mid-sample -> no valid_out, ready_out=1 next cycle, following impulse gives a fresh response from zero history.
